// File: rtl/alu_exec_if.sv
// Handshake bundle for alu_exec_stage.
//   slave  : stage side (takes operations, drives results)
//   master : producer/consumer side
// Signals: in_valid/in_ready/alu_ctrl/op_a/op_b/in_tag (operation in),
//          out_valid/out_ready/result/zero/illegal/out_tag (head result out),
//          illegal_count (debug counter).
interface alu_exec_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic             zero;
  logic             illegal;
  logic [TAG_W-1:0] out_tag;
  logic [15:0]      illegal_count;

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, in_tag, out_ready,
    output in_ready, out_valid, result, zero, illegal, out_tag, illegal_count
  );

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, in_tag, out_ready,
    input  in_ready, out_valid, result, zero, illegal, out_tag, illegal_count
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU feeding a 2-entry result FIFO.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : alu_exec_if.slave -- operation handshake in, head result out,
//          saturating illegal-op counter
module alu_exec_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);

  logic [XLEN-1:0]  r_res  [2];
  logic             r_zero [2];
  logic             r_ill  [2];
  logic [TAG_W-1:0] r_tag  [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic [15:0]      r_illegal_count;

  logic [XLEN-1:0]  w_alu_res;
  logic             w_illegal_op;
  logic             w_push;
  logic             w_pop;
  logic             w_has_head;
  logic [1:0]       w_count_nxt;

  // in_ready comes only from registered count, so no out_ready -> in_ready path.
  assign bus.in_ready  = (r_count != 2'd2);
  assign bus.out_valid = w_has_head;
  assign w_has_head    = (r_count != 2'd0);
  assign w_push        = bus.in_valid && bus.in_ready;
  assign w_pop         = w_has_head && bus.out_ready;

  always_comb begin
    w_alu_res    = '0;
    w_illegal_op = 1'b0;
    case (bus.alu_ctrl)
      4'b0000: w_alu_res = bus.op_a + bus.op_b;
      4'b0001: w_alu_res = bus.op_a - bus.op_b;
      4'b0010: w_alu_res = bus.op_a & bus.op_b;
      4'b0011: w_alu_res = bus.op_a | bus.op_b;
      4'b0100: w_alu_res = bus.op_a ^ bus.op_b;
      default: w_illegal_op = 1'b1;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr        <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_count         <= 2'd0;
      r_illegal_count <= 16'd0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      if (w_push && w_illegal_op && (r_illegal_count != 16'hFFFF)) begin
        r_illegal_count <= r_illegal_count + 16'd1;
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_res[r_wr_ptr]  <= w_alu_res;
      r_zero[r_wr_ptr] <= (w_alu_res == '0);
      r_ill[r_wr_ptr]  <= w_illegal_op;
      r_tag[r_wr_ptr]  <= bus.in_tag;
    end
  end

  assign bus.result        = w_has_head ? r_res[r_rd_ptr]  : '0;
  assign bus.zero          = w_has_head ? r_zero[r_rd_ptr] : 1'b0;
  assign bus.illegal       = w_has_head ? r_ill[r_rd_ptr]  : 1'b0;
  assign bus.out_tag       = w_has_head ? r_tag[r_rd_ptr]  : '0;
  assign bus.illegal_count = r_illegal_count;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomised bench for alu_exec_stage with a queue-based reference model.
module tb_alu_exec_stage;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    logic [4:0]  tag;
  } entry_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  bit   chk_en;

  entry_t q[$];
  int     m_ill_cnt;

  alu_exec_if #(.XLEN(32), .TAG_W(5)) bus ();

  alu_exec_stage #(.XLEN(32), .TAG_W(5)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic entry_t ref_op(input logic [3:0] c, input logic [31:0] a,
                                    input logic [31:0] b, input logic [4:0] t);
    entry_t e;
    e.ill = 1'b0;
    case (c)
      4'd0:    e.res = a + b;
      4'd1:    e.res = a - b;
      4'd2:    e.res = a & b;
      4'd3:    e.res = a | b;
      4'd4:    e.res = a ^ b;
      default: begin e.res = 32'd0; e.ill = 1'b1; end
    endcase
    e.zero = (e.res == 32'd0);
    e.tag  = t;
    return e;
  endfunction

  // One clock cycle: drive inputs, check against model mid-cycle, advance model at edge.
  task automatic step(input logic v, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] t, input logic ordy);
    bit     push;
    bit     pop;
    entry_t e;
    bus.in_valid  = v;
    bus.alu_ctrl  = c;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.in_tag    = t;
    bus.out_ready = ordy;
    @(negedge clk);
    if (chk_en) begin
      check_eq("out_valid", bus.out_valid, q.size() != 0);
      check_eq("in_ready", bus.in_ready, q.size() < 2);
      check_eq("illegal_count", bus.illegal_count, m_ill_cnt);
      if (q.size() != 0) begin
        check_eq("head_result", bus.result, q[0].res);
        check_eq("head_zero", bus.zero, q[0].zero);
        check_eq("head_illegal", bus.illegal, q[0].ill);
        check_eq("head_tag", bus.out_tag, q[0].tag);
      end
    end
    push = !rst && v && (q.size() < 2);
    pop  = !rst && ordy && (q.size() != 0);
    e    = ref_op(c, a, b, t);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ill_cnt = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(e);
        if (e.ill && m_ill_cnt != 65535) m_ill_cnt++;
      end
    end
    #1;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] res, input logic z,
                             input logic il, input logic [4:0] t);
    check_eq({tag, "_valid"}, bus.out_valid, 1'b1);
    check_eq({tag, "_result"}, bus.result, res);
    check_eq({tag, "_zero"}, bus.zero, z);
    check_eq({tag, "_illegal"}, bus.illegal, il);
    check_eq({tag, "_tag"}, bus.out_tag, t);
  endtask

  initial begin
    logic [31:0] la;
    logic [31:0] lb;
    n_checks  = 0;
    n_pass    = 0;
    chk_en    = 1'b0;
    m_ill_cnt = 0;
    rst       = 1'b1;
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    rst    = 1'b0;
    chk_en = 1'b1;
    check_eq("rst_in_ready", bus.in_ready, 1'b1);
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_result", bus.result, 32'd0);
    check_eq("rst_zero", bus.zero, 1'b0);
    check_eq("rst_illegal", bus.illegal, 1'b0);
    check_eq("rst_tag", bus.out_tag, 5'd0);
    check_eq("rst_ill_cnt", bus.illegal_count, 16'd0);

    // Directed ops; each push also pops the previous one (push+pop at count 1).
    la = 32'hF0F0_00FF;
    lb = 32'h0FF0_0F0F;
    step(1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1);
    expect_head("add", 32'd12, 1'b0, 1'b0, 5'd3);
    step(1'b1, 4'd1, 32'd3, 32'd3, 5'd4, 1'b1);
    expect_head("sub_zero", 32'd0, 1'b1, 1'b0, 5'd4);
    check_eq("pushpop_in_ready", bus.in_ready, 1'b1);
    step(1'b1, 4'd1, 32'd0, 32'd1, 5'd5, 1'b1);
    expect_head("sub_wrap", 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd5);
    step(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1);
    expect_head("add_wrap", 32'd0, 1'b1, 1'b0, 5'd6);
    step(1'b1, 4'd2, la, lb, 5'd7, 1'b1);
    expect_head("and", 32'h00F0_000F, 1'b0, 1'b0, 5'd7);
    step(1'b1, 4'd3, la, lb, 5'd8, 1'b1);
    expect_head("or", 32'hFFF0_0FFF, 1'b0, 1'b0, 5'd8);
    step(1'b1, 4'd4, la, lb, 5'd10, 1'b1);
    expect_head("xor", 32'hFF00_0FF0, 1'b0, 1'b0, 5'd10);
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);
    check_eq("drain_valid", bus.out_valid, 1'b0);

    // Back-pressure: tag 3 rejected while full.
    step(1'b1, 4'd0, 32'd1, 32'd1, 5'd1, 1'b0);
    step(1'b1, 4'd0, 32'd2, 32'd2, 5'd2, 1'b0);
    check_eq("full_in_ready", bus.in_ready, 1'b0);
    step(1'b1, 4'd0, 32'd3, 32'd3, 5'd3, 1'b0);
    expect_head("bp_hold", 32'd2, 1'b0, 1'b0, 5'd1);
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);
    expect_head("bp_pop1", 32'd4, 1'b0, 1'b0, 5'd2);
    check_eq("bp_in_ready", bus.in_ready, 1'b1);
    step(1'b1, 4'd0, 32'd3, 32'd3, 5'd3, 1'b1);
    expect_head("bp_tag3", 32'd6, 1'b0, 1'b0, 5'd3);
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);
    check_eq("bp_empty", bus.out_valid, 1'b0);

    // Illegal code, then reset while full.
    step(1'b1, 4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, 1'b0);
    expect_head("illegal", 32'd0, 1'b1, 1'b1, 5'd9);
    check_eq("ill_cnt_one", bus.illegal_count, 16'd1);
    step(1'b1, 4'd0, 32'd1, 32'd1, 5'd11, 1'b0);
    check_eq("full_before_rst", bus.in_ready, 1'b0);
    rst = 1'b1;
    step(1'b1, 4'd0, 32'd1, 32'd1, 5'd12, 1'b0);
    rst = 1'b0;
    check_eq("rst_mid_valid", bus.out_valid, 1'b0);
    check_eq("rst_mid_ready", bus.in_ready, 1'b1);
    check_eq("rst_mid_cnt", bus.illegal_count, 16'd0);

    // Random traffic, including occasional resets and illegal codes.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] c;
      c   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      rst = ($urandom_range(0, 63) == 0);
      step(1'($urandom_range(0, 1)), c, $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
           5'($urandom), ($urandom_range(0, 2) != 0));
    end
    rst = 1'b0;
    // Sustained throughput with out_ready held high.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'($urandom_range(0, 4)), $urandom, $urandom, 5'($urandom), 1'b1);
      check_eq("thru_in_ready", bus.in_ready, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
